// File: rtl/cvs_divider_bank.sv
// cvs_divider_bank
//
// Bank of CHANNELS independent programmable clock dividers for the CVS
// board's LED and test-point outputs, all clocked from one system clock.
// Every channel has its own half-period H, mode (toggle or pulse) and run
// enable, and all of them can be reprogrammed at runtime through a
// one-word configuration port.
//
// Optional feature macro: CVS_SYNC_START_EN
//   When defined, the input sync_start is added. It clears every channel's
//   counter, out and tick on the next edge, so all outputs can be brought
//   into phase. H and mode are kept.
//
// Parameters:
//   CHANNELS     number of divider channels (1..16)
//   COUNT_WIDTH  width of the half-period value and per-channel counter
//   CH_IDX_W     width of the channel index (derived)
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   enable           per-channel run enable (level)
//   cfg_valid        configuration write strobe
//   cfg_channel      channel targeted by the write
//   cfg_half_period  new half-period H
//   cfg_mode         0 = toggle (square wave), 1 = pulse (one-cycle strobe)
//   sync_start       phase-align all channels (CVS_SYNC_START_EN only)
//   cfg_error        one-cycle pulse when a write targets a missing channel
//   out              divided outputs, registered
//   tick             one-cycle strobe after every wrap, registered
module cvs_divider_bank #(
    parameter int CHANNELS    = 5,
    parameter int COUNT_WIDTH = 24,
    localparam int CH_IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    enable,
    input  logic                   cfg_valid,
    input  logic [CH_IDX_W-1:0]    cfg_channel,
    input  logic [COUNT_WIDTH-1:0] cfg_half_period,
    input  logic                   cfg_mode,
`ifdef CVS_SYNC_START_EN
    input  logic                   sync_start,
`endif
    output logic                   cfg_error,
    output logic [CHANNELS-1:0]    out,
    output logic [CHANNELS-1:0]    tick
);

    localparam logic [CH_IDX_W:0] CH_LIMIT = (CH_IDX_W + 1)'(CHANNELS);

    logic [COUNT_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] cnt_d  [CHANNELS];
    logic [COUNT_WIDTH-1:0] half_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] half_d [CHANNELS];
    logic [CHANNELS-1:0]    mode_q, mode_d;
    logic [CHANNELS-1:0]    out_q, out_d;
    logic [CHANNELS-1:0]    tick_q, tick_d;
    logic                   cfg_error_q, cfg_error_d;
    logic                   cfg_in_range;
    logic                   sync_clear;

    // The index is widened by one bit so the range check also works when
    // CHANNELS is a power of two (every index then happens to be legal).
    assign cfg_in_range = ({1'b0, cfg_channel} < CH_LIMIT);

`ifdef CVS_SYNC_START_EN
    assign sync_clear = sync_start;
`else
    assign sync_clear = 1'b0;
`endif

    // Priority per channel: config write, then sync clear, then normal
    // counting. A write landing on a wrap therefore suppresses both the
    // toggle and the tick for that channel.
    always_comb begin
        cfg_error_d = cfg_valid & ~cfg_in_range;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            half_d[i] = half_q[i];
            mode_d[i] = mode_q[i];
            out_d[i]  = out_q[i];
            tick_d[i] = 1'b0;
            if (cfg_valid && cfg_in_range && (cfg_channel == CH_IDX_W'(i))) begin
                half_d[i] = cfg_half_period;
                mode_d[i] = cfg_mode;
                cnt_d[i]  = '0;
                out_d[i]  = 1'b0;
            end else if (sync_clear) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
            end else if (enable[i]) begin
                // The counter never passes H, so equality is the only wrap
                // condition needed and the counter cannot roll over.
                if (cnt_q[i] == half_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    out_d[i]  = mode_q[i] ? 1'b1 : ~out_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
                    if (mode_q[i]) begin
                        out_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // State registers; reset also overrides a concurrent config write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                half_q[i] <= '0;
            end
            mode_q      <= '0;
            out_q       <= '0;
            tick_q      <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            tick_q      <= tick_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign out       = out_q;
    assign tick      = tick_q;
    assign cfg_error = cfg_error_q;

endmodule
